// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO burst reader.
package fifo_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_LEN_W      = 8;
    localparam int BUF_DEPTH      = 2;
    localparam int OCC_W          = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W          = $clog2(BUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } rd_state_e;
endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer absorbing the FIFO read latency.
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [OCC_W-1:0]      occ
);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst read master: pops burst_len FIFO words onto a valid/ready stream.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_W      = DEF_LEN_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_W-1:0]      burst_len,
    output logic                  busy,
    output logic                  done,
    output logic                  fifo_r_en,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [LEN_W-1:0]      words_left
);

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    rd_state_e        state;
    rd_state_e        state_nx;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] issued_q;
    logic [LEN_W-1:0] left_q;
    logic             inflight_q;
    logic [OCC_W-1:0] occ;
    logic [OCC_W:0]   use_nx;
    logic             pop;

    assign m_valid    = (occ != '0);
    assign pop        = m_valid && m_ready;
    assign busy       = (state == READ) || (state == DRAIN);
    assign done       = (state == DONE);
    assign words_left = left_q;

    // Slots committed after this edge: held words plus the one in flight.
    assign use_nx = {1'b0, occ}
                  + (OCC_W + 1)'(inflight_q)
                  - (OCC_W + 1)'(pop);

    always_comb begin
        state_nx  = state;
        fifo_r_en = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (burst_len == '0) ? DONE : READ;
                end
            end
            READ: begin
                fifo_r_en = !fifo_empty
                         && (issued_q < len_q)
                         && (use_nx < (OCC_W + 1)'(BUF_DEPTH));
                if (fifo_r_en && ((issued_q + ONE) == len_q)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && (left_q == ONE)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            left_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            state      <= state_nx;
            inflight_q <= fifo_r_en;
            if ((state == IDLE) && start) begin
                len_q    <= burst_len;
                left_q   <= burst_len;
                issued_q <= '0;
            end else begin
                if (fifo_r_en) begin
                    issued_q <= issued_q + ONE;
                end
                if (pop && (left_q != '0)) begin
                    left_q <= left_q - ONE;
                end
            end
        end
    end

    fifo_rd_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (fifo_data_out),
        .pop       (pop),
        .head_data (m_data),
        .occ       (occ)
    );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a FIFO model and stream scoreboard.
module tb_fifo_burst_reader;

    localparam int DW = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] burst_len = '0;
    logic          busy;
    logic          done;
    logic          fifo_r_en;
    logic [DW-1:0] fifo_data_out = '0;
    logic          fifo_empty = 1'b1;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [LW-1:0] words_left;

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .DATA_WIDTH(DW),
        .LEN_W     (LW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .burst_len     (burst_len),
        .busy          (busy),
        .done          (done),
        .fifo_r_en     (fifo_r_en),
        .fifo_data_out (fifo_data_out),
        .fifo_empty    (fifo_empty),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .words_left    (words_left)
    );

    // Source FIFO: registered read data, popped words logged in order.
    logic [DW-1:0] fq[$];
    logic [DW-1:0] popq[$];
    int            rcyc[$];
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    int            cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_r_en && fq.size() > 0) begin
            fifo_data_out <= fq[0];
            popq.push_back(fq[0]);
            rcyc.push_back(cyc);
            void'(fq.pop_front());
        end
        if (wr_en) fq.push_back(wr_data);
        fifo_empty <= (fq.size() == 0);
    end

    // Transaction-level model of burst progress.
    logic          m_busy = 1'b0;
    logic          m_done = 1'b0;
    logic [LW-1:0] m_left = '0;
    int            ndel = 0;
    logic          hs_n = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= '0;
            ndel   <= popq.size();
        end else begin
            m_done <= 1'b0;
            if (!m_busy && !m_done && start) begin
                m_left <= burst_len;
                if (burst_len == 0) m_done <= 1'b1;
                else                m_busy <= 1'b1;
            end else if (hs_n) begin
                ndel <= ndel + 1;
                if (m_left != 0) m_left <= m_left - 1;
                if (m_busy && m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
            end
        end
    end

    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] got[$];
    int            gcyc[$];
    int            done_cyc = 0;
    int            ndone = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_cycle();
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("words_left", 32'(words_left), 32'(m_left));
        if (fifo_r_en) begin
            chk("r_en_while_empty", 32'(fifo_empty), 0);
            chk("r_en_while_idle", 32'(busy), 1);
        end
        if (!rst_n) chk("valid_in_reset", 32'(m_valid), 0);
        if (prev_stall) begin
            chk("stall_valid", 32'(m_valid), 1);
            chk("stall_data", 32'(m_data), 32'(prev_data));
        end
        hs_n = m_valid && m_ready;
        if (hs_n) begin
            if (ndel < popq.size()) chk("order", 32'(m_data), 32'(popq[ndel]));
            else chk("order_extra_word", 32'(m_data), 32'hFFFF_FFFF);
            got.push_back(m_data);
            gcyc.push_back(cyc);
        end
        if (done) begin
            done_cyc = cyc;
            ndone++;
        end
        prev_stall = rst_n && m_valid && !m_ready;
        prev_data  = m_data;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            check_cycle();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic preload(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = base + DW'(i);
            tick(1);
        end
        wr_en = 1'b0;
        tick(1);
    endtask

    task automatic go(input int len);
        burst_len = LW'(len);
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int  k;
        logic found;
        k = 0;
        found = 1'b0;
        while (!found && k < maxc) begin
            @(negedge clk);
            check_cycle();
            if (done) found = 1'b1;
            @(posedge clk);
            #1;
            k++;
        end
        chk("done_within_budget", 32'(found), 1);
    endtask

    task automatic chk_words(input string name, input int b0,
                             input logic [DW-1:0] base, input int n);
        chk(name, 32'(got.size() - b0), 32'(n));
        if (got.size() - b0 == n) begin
            for (int i = 0; i < n; i++) begin
                chk(name, 32'(got[b0 + i]), 32'(base + DW'(i)));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int rc0;
        int d0;
        int k;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_r_en", 32'(fifo_r_en), 0);
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_data", 32'(m_data), 0);
        chk("rst_left", 32'(words_left), 0);
        rst_n = 1'b1;
        tick(1);

        // Streaming burst with consumer always ready.
        preload(8'h11, 5);
        m_ready = 1'b1;
        b0  = got.size();
        rc0 = rcyc.size();
        go(5);
        wait_done(60);
        chk_words("t1_data", b0, 8'h11, 5);
        chk("t1_ren_count", 32'(rcyc.size() - rc0), 5);
        if (rcyc.size() - rc0 == 5 && got.size() - b0 == 5) begin
            chk("t1_ren_consec", 32'(rcyc[rc0 + 4] - rcyc[rc0]), 4);
            chk("t1_data_consec", 32'(gcyc[b0 + 4] - gcyc[b0]), 4);
            chk("t1_done_after_last", 32'(done_cyc - gcyc[b0 + 4]), 1);
        end
        tick(1);
        chk("t1_fifo_empty", 32'(fifo_empty), 1);
        chk("t1_left", 32'(words_left), 0);

        // Consumer stalled for 10 cycles.
        preload(8'h11, 5);
        m_ready = 1'b0;
        b0  = got.size();
        rc0 = rcyc.size();
        go(5);
        tick(9);
        chk("t2_stall_ren", 32'(rcyc.size() - rc0), 2);
        chk("t2_stall_valid", 32'(m_valid), 1);
        chk("t2_stall_data", 32'(m_data), 32'h11);
        m_ready = 1'b1;
        wait_done(60);
        chk_words("t2_data", b0, 8'h11, 5);

        // FIFO starts empty and fills slowly.
        b0  = got.size();
        rc0 = rcyc.size();
        go(3);
        tick(3);
        wr_en = 1'b1; wr_data = 8'hA0; tick(1); wr_en = 1'b0;
        tick(3);
        wr_en = 1'b1; wr_data = 8'hA1; tick(1); wr_en = 1'b0;
        tick(3);
        wr_en = 1'b1; wr_data = 8'hA2; tick(1); wr_en = 1'b0;
        wait_done(40);
        chk_words("t3_data", b0, 8'hA0, 3);
        chk("t3_ren_count", 32'(rcyc.size() - rc0), 3);

        // Zero-length burst.
        rc0 = rcyc.size();
        go(0);
        chk("t4_done", 32'(done), 1);
        chk("t4_busy", 32'(busy), 0);
        tick(3);
        chk("t4_no_ren", 32'(rcyc.size() - rc0), 0);

        // Second start mid-burst is ignored.
        preload(8'h30, 8);
        b0  = got.size();
        rc0 = rcyc.size();
        go(6);
        tick(2);
        burst_len = 2;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(60);
        chk_words("t5_data", b0, 8'h30, 6);
        chk("t5_ren_count", 32'(rcyc.size() - rc0), 6);
        chk("t5_fifo_left", 32'(fq.size()), 2);
        d0 = ndone;
        tick(5);
        chk("t5_no_extra_done", 32'(ndone - d0), 0);
        b0 = got.size();
        go(2);
        wait_done(40);
        chk_words("t5_drain", b0, 8'h36, 2);

        // Reset after three of six words delivered.
        preload(8'h40, 8);
        b0 = got.size();
        go(6);
        k = 0;
        while (got.size() - b0 < 3 && k < 40) begin
            @(negedge clk);
            check_cycle();
            @(posedge clk);
            k++;
        end
        chk("t6_reached_three", 32'(got.size() - b0), 3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_done", 32'(done), 0);
        chk("t6_rst_r_en", 32'(fifo_r_en), 0);
        chk("t6_rst_valid", 32'(m_valid), 0);
        chk("t6_rst_data", 32'(m_data), 0);
        chk("t6_rst_left", 32'(words_left), 0);
        d0 = ndone;
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(4);
        chk("t6_no_done", 32'(ndone - d0), 0);
        chk("t6_fifo_left", 32'(fq.size()), 3);
        b0 = got.size();
        go(1);
        wait_done(40);
        chk_words("t6_after_reset", b0, 8'h45, 1);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
